// File: rtl/lsu_align_if.sv
// Core-request, response and word-RAM signals for the load/store alignment unit.
// The slave modport is the alignment unit; master is the core plus memory side.
interface lsu_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte/half/word requests at any byte address into
// one or two word-aligned RAM accesses and extends the returned load data.
module lsu_align #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    lsu_align_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC0  = 3'd1,
        ACC1  = 3'd2,
        WAIT1 = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic [31:0] mem_addr_r;
    logic        mem_rstrb_r;
    logic [3:0]  mem_wmask_r;
    logic [31:0] mem_wdata_r;

    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        split_r;
    logic        err_pend_r;
    logic [3:0]  wmask_hi_r;
    logic [31:0] wdata_hi_r;
    logic [31:0] lo_r;

    logic [1:0]  off_s;
    logic [2:0]  bytes_s;
    logic        size_bad_s;
    logic        split_s;
    logic [7:0]  m8_s;
    logic [63:0] d64_s;
    logic        reject_s;

    // Shift the {hi, lo} pair down to the addressed byte and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = 32'(pair >> {off, 3'b000});
        case (funct3[1:0])
            2'b00: begin
                if (funct3[2]) r = {24'd0, sh[7:0]};
                else           r = {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                if (funct3[2]) r = {16'd0, sh[15:0]};
                else           r = {{16{sh[15]}}, sh[15:0]};
            end
            default: r = sh;
        endcase
        return r;
    endfunction

    assign off_s = bus.req_addr[1:0];

    // Decode size, lane mask, shifted store data and the split/reject decision.
    always_comb begin
        bytes_s    = 3'd1;
        size_bad_s = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   bytes_s = 3'd1;
            2'b01:   bytes_s = 3'd2;
            2'b10:   bytes_s = 3'd4;
            default: begin
                bytes_s    = 3'd1;
                size_bad_s = 1'b1;
            end
        endcase
        split_s  = (({1'b0, off_s} + bytes_s) > 3'd4);
        m8_s     = ((8'd1 << bytes_s) - 8'd1) << off_s;
        d64_s    = {32'd0, bus.req_wdata} << {off_s, 3'b000};
        reject_s = size_bad_s | (split_s & ~ALLOW_MISALIGNED);
    end

    // Sequencer: every output is a register written here, strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_rstrb_r <= 1'b0;
            mem_wmask_r <= 4'd0;
            mem_wdata_r <= 32'd0;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            off_r       <= 2'd0;
            split_r     <= 1'b0;
            err_pend_r  <= 1'b0;
            wmask_hi_r  <= 4'd0;
            wdata_hi_r  <= 32'd0;
            lo_r        <= 32'd0;
        end else begin
            mem_rstrb_r <= 1'b0;
            mem_wmask_r <= 4'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_r <= 1'b0;
                        we_r        <= bus.req_we;
                        funct3_r    <= bus.req_funct3;
                        off_r       <= off_s;
                        split_r     <= split_s;
                        wmask_hi_r  <= m8_s[7:4];
                        wdata_hi_r  <= d64_s[63:32];
                        if (reject_s) begin
                            // Errors spend one silent cycle in RESP so the reply lands at T+2.
                            err_pend_r <= 1'b1;
                            state_r    <= RESP;
                        end else begin
                            err_pend_r <= 1'b0;
                            state_r    <= ACC0;
                            mem_addr_r <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we) begin
                                mem_wmask_r <= m8_s[3:0];
                                mem_wdata_r <= d64_s[31:0];
                            end else begin
                                mem_rstrb_r <= 1'b1;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC0: begin
                    state_r <= ACC1;
                    if (split_r) begin
                        mem_addr_r <= mem_addr_r + 32'd4;
                        if (we_r) begin
                            mem_wmask_r <= wmask_hi_r;
                            mem_wdata_r <= wdata_hi_r;
                        end else begin
                            mem_rstrb_r <= 1'b1;
                        end
                    end else begin
                        mem_addr_r <= mem_addr_r;
                    end
                end
                ACC1: begin
                    lo_r <= bus.mem_rdata;
                    if (split_r) begin
                        state_r <= WAIT1;
                    end else begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        if (we_r) rsp_rdata_r <= 32'd0;
                        else      rsp_rdata_r <= load_extend({32'd0, bus.mem_rdata}, off_r, funct3_r);
                    end
                end
                WAIT1: begin
                    state_r     <= RESP;
                    rsp_valid_r <= 1'b1;
                    if (we_r) rsp_rdata_r <= 32'd0;
                    else      rsp_rdata_r <= load_extend({bus.mem_rdata, lo_r}, off_r, funct3_r);
                end
                RESP: begin
                    if (err_pend_r) begin
                        err_pend_r  <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    err_pend_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_rstrb = mem_rstrb_r;
    assign bus.mem_wmask = mem_wmask_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: one instance splitting misaligned accesses, one rejecting them,
// both fed identical requests and checked against hand-computed vectors.
module tb_lsu_align;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_align_if if_a ();
    lsu_align_if if_b ();

    lsu_align #(.ALLOW_MISALIGNED(1'b1)) dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));
    lsu_align #(.ALLOW_MISALIGNED(1'b0)) dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));

    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        case (idx)
            30'd100:        return 32'h04030201;
            30'd101:        return 32'h08070605;
            30'd103:        return 32'hFF0F0E0D;
            30'h3FFFFFFF:   return 32'h44332211;
            30'd0:          return 32'h88776655;
            default:        return 32'h00000000;
        endcase
    endfunction

    // Word RAM with one-cycle registered read; poison value when not strobed.
    always @(posedge clk) begin
        if_a.mem_rdata <= if_a.mem_rstrb ? mem_word(if_a.mem_addr[31:2]) : 32'hBAD0BAD0;
        if_b.mem_rdata <= if_b.mem_rstrb ? mem_word(if_b.mem_addr[31:2]) : 32'hBAD0BAD0;
    end

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] addr;
        logic        rstrb;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    always @(negedge clk) begin
        if (if_a.mem_rstrb || if_a.mem_wmask != 4'd0)
            acc_q.push_back('{0, cyc, if_a.mem_addr, if_a.mem_rstrb, if_a.mem_wmask, if_a.mem_wdata});
        if (if_b.mem_rstrb || if_b.mem_wmask != 4'd0)
            acc_q.push_back('{1, cyc, if_b.mem_addr, if_b.mem_rstrb, if_b.mem_wmask, if_b.mem_wdata});
        if (if_a.rsp_valid) rsp_q.push_back('{0, cyc, if_a.rsp_rdata, if_a.rsp_err});
        if (if_b.rsp_valid) rsp_q.push_back('{1, cyc, if_b.rsp_rdata, if_b.rsp_err});
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        split;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  m0;
        logic [31:0] w0;
        logic [3:0]  m1;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic valid);
        if_a.req_we = we; if_a.req_funct3 = f3; if_a.req_addr = addr; if_a.req_wdata = wdata; if_a.req_valid = valid;
        if_b.req_we = we; if_b.req_funct3 = f3; if_b.req_addr = addr; if_b.req_wdata = wdata; if_b.req_valid = valid;
    endtask

    // Present a request at a negedge, then keep req_valid high with junk fields while busy.
    task automatic start_req(input vec_t v, output int t);
        set_req(v.we, v.f3, v.addr, v.wdata, 1'b1);
        t = cyc;
        chk({v.name, " ready_a"}, 32'(if_a.req_ready), 32'd1);
        chk({v.name, " ready_b"}, 32'(if_b.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 3'b000, 32'h00000200, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        set_req(1'b1, 3'b010, 32'h00000204, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        set_req(1'b0, 3'b000, 32'h00000000, 32'h00000000, 1'b0);
    endtask

    task automatic check_dut(input int d, input int t, input vec_t v);
        logic        rej;
        int          lat;
        int          nacc;
        int          n;
        string       tag;
        tag  = $sformatf("%s[%s]", v.name, (d == 0) ? "A" : "B");
        rej  = v.err | ((d == 1) & v.split);
        lat  = rej ? 2 : (v.split ? 4 : 3);
        nacc = rej ? 0 : (v.split ? 2 : 1);
        n = 0;
        foreach (rsp_q[i]) begin
            if (rsp_q[i].dut == d) begin
                if (n == 0) begin
                    chk({tag, " rsp_cyc"}, 32'(rsp_q[i].cyc), 32'(t + lat));
                    chk({tag, " rdata"}, rsp_q[i].rdata, rej ? 32'd0 : v.rdata);
                    chk({tag, " err"}, 32'(rsp_q[i].err), 32'(rej));
                end
                n++;
            end
        end
        chk({tag, " rsp_cnt"}, 32'(n), 32'd1);
        n = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].dut == d) begin
                if (n < nacc) begin
                    chk($sformatf("%s acc%0d_cyc", tag, n), 32'(acc_q[i].cyc), 32'(t + 1 + n));
                    chk($sformatf("%s acc%0d_addr", tag, n), acc_q[i].addr, (n == 0) ? v.a0 : v.a1);
                    chk($sformatf("%s acc%0d_rstrb", tag, n), 32'(acc_q[i].rstrb), 32'(!v.we));
                    chk($sformatf("%s acc%0d_mask", tag, n), 32'(acc_q[i].mask),
                        v.we ? 32'((n == 0) ? v.m0 : v.m1) : 32'd0);
                    if (v.we)
                        chk($sformatf("%s acc%0d_wdata", tag, n), acc_q[i].wdata, (n == 0) ? v.w0 : v.w1);
                end
                n++;
            end
        end
        chk({tag, " acc_cnt"}, 32'(n), 32'(nacc));
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        rsp_q.delete();
        acc_q.delete();
        start_req(v, t);
        repeat (5) @(negedge clk);
        check_dut(0, t, v);
        check_dut(1, t, v);
    endtask

    task automatic check_zero(input int d, input string nm);
        if (d == 0) begin
            chk({nm, " ready"}, 32'(if_a.req_ready), 32'd1);
            chk({nm, " outs"}, 32'({if_a.rsp_valid, if_a.rsp_err, if_a.mem_rstrb, if_a.mem_wmask}), 32'd0);
            chk({nm, " rdata"}, if_a.rsp_rdata, 32'd0);
            chk({nm, " maddr"}, if_a.mem_addr, 32'd0);
            chk({nm, " mwdata"}, if_a.mem_wdata, 32'd0);
        end else begin
            chk({nm, " ready"}, 32'(if_b.req_ready), 32'd1);
            chk({nm, " outs"}, 32'({if_b.rsp_valid, if_b.rsp_err, if_b.mem_rstrb, if_b.mem_wmask}), 32'd0);
            chk({nm, " rdata"}, if_b.rsp_rdata, 32'd0);
            chk({nm, " maddr"}, if_b.mem_addr, 32'd0);
            chk({nm, " mwdata"}, if_b.mem_wdata, 32'd0);
        end
    endtask

    initial begin
        int   t;
        int   n;
        vec_t lw401;

        //           name      we    f3      addr          wdata         split err   rdata         a0            a1            m0       w0            m1       w1
        vecs.push_back('{"lb400",   1'b0, 3'b000, 32'd400,      32'd0,        1'b0, 1'b0, 32'h00000001, 32'd400,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lb415",   1'b0, 3'b000, 32'd415,      32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'd412,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lbu415",  1'b0, 3'b100, 32'd415,      32'd0,        1'b0, 1'b0, 32'h000000FF, 32'd412,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lh402",   1'b0, 3'b001, 32'd402,      32'd0,        1'b0, 1'b0, 32'h00000403, 32'd400,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lh414",   1'b0, 3'b001, 32'd414,      32'd0,        1'b0, 1'b0, 32'hFFFFFF0F, 32'd412,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lw401",   1'b0, 3'b010, 32'd401,      32'd0,        1'b1, 1'b0, 32'h05040302, 32'd400,      32'd404,      4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lhu403",  1'b0, 3'b101, 32'd403,      32'd0,        1'b1, 1'b0, 32'h00000504, 32'd400,      32'd404,      4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"sb401",   1'b1, 3'b000, 32'd401,      32'h000000AB, 1'b0, 1'b0, 32'd0,        32'd400,      32'd0,        4'b0010, 32'h0000AB00, 4'b0000, 32'd0});
        vecs.push_back('{"sh402",   1'b1, 3'b001, 32'd402,      32'h00001234, 1'b0, 1'b0, 32'd0,        32'd400,      32'd0,        4'b1100, 32'h12340000, 4'b0000, 32'd0});
        vecs.push_back('{"sb415",   1'b1, 3'b000, 32'd415,      32'h00000077, 1'b0, 1'b0, 32'd0,        32'd412,      32'd0,        4'b1000, 32'h77000000, 4'b0000, 32'd0});
        vecs.push_back('{"sw403",   1'b1, 3'b010, 32'd403,      32'h11223344, 1'b1, 1'b0, 32'd0,        32'd400,      32'd404,      4'b1000, 32'h44000000, 4'b0111, 32'h00112233});
        vecs.push_back('{"lwwrap",  1'b0, 3'b010, 32'hFFFFFFFE, 32'd0,        1'b1, 1'b0, 32'h66554433, 32'hFFFFFFFC, 32'h00000000, 4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"ill_ld",  1'b0, 3'b011, 32'd401,      32'd0,        1'b0, 1'b1, 32'd0,        32'd0,        32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"ill_st",  1'b1, 3'b011, 32'd400,      32'h00000055, 1'b0, 1'b1, 32'd0,        32'd0,        32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});
        vecs.push_back('{"lw400",   1'b0, 3'b010, 32'd400,      32'd0,        1'b0, 1'b0, 32'h04030201, 32'd400,      32'd0,        4'b0000, 32'd0,        4'b0000, 32'd0});

        set_req(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Split load aborted by reset while waiting for its second word.
        lw401 = vecs[5];
        rsp_q.delete();
        acc_q.delete();
        start_req(lw401, t);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_zero(0, "abort_a");
        check_zero(1, "abort_b");
        repeat (5) @(negedge clk);
        n = 0;
        foreach (rsp_q[i]) if (rsp_q[i].dut == 0) n++;
        chk("abort rsp_cnt_a", 32'(n), 32'd0);
        n = 0;
        foreach (acc_q[i]) if (acc_q[i].dut == 0) n++;
        chk("abort acc_cnt_a", 32'(n), 32'd2);

        lw401 = vecs[0];
        lw401.name = "lb400_post";
        run_vec(lw401);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
